// File: rtl/psum_fifo_ctrl_if.sv
// ============================================================================
//  Module   : psum_fifo_ctrl_if
//  Purpose  : Job control, adder-tree feedback and final-sum bus for psum_fifo_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface psum_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 25,
    parameter int ADDR_WIDTH = 6,
    parameter int PASS_WIDTH = 8
) ();
    logic                  start;
    logic [ADDR_WIDTH:0]   cfg_len;
    logic [PASS_WIDTH-1:0] cfg_pass;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] sum_in;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;
    logic                  done;

    // master: the sequencer / adder tree side
    modport master (
        output start, cfg_len, cfg_pass, in_valid, sum_in,
        input  fifo_data, out_valid, out_data, busy, done
    );

    modport slave (
        input  start, cfg_len, cfg_pass, in_valid, sum_in,
        output fifo_data, out_valid, out_data, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/psum_fifo_ctrl.sv
// ============================================================================
//  Module   : psum_fifo_ctrl
//  Purpose  : Partial-sum feedback buffer for the 3-stage psum adder tree.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_fifo_ctrl #(
    parameter int DATA_WIDTH = 25,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int PASS_WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    psum_fifo_ctrl_if.slave bus
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1 + PASS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [PASS_WIDTH-1:0] r_pass;
    logic [CNT_WIDTH-1:0]  r_total;
    logic [CNT_WIDTH-1:0]  r_acc_cnt;
    logic [2:0]            r_vld;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [PASS_WIDTH-1:0] r_rd_pass;
    logic [PASS_WIDTH-1:0] r_wr_pass;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_done;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH:0]   w_cfg_len;
    logic [PASS_WIDTH-1:0] w_cfg_pass;
    logic [CNT_WIDTH-1:0]  w_cfg_total;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_last_addr;
    logic [PASS_WIDTH-1:0] w_final_pass;
    logic                  w_wr_final;
    logic                  w_wr_mem;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_fifo_data;

    // Zero length / zero pass configurations behave as 1
    assign w_cfg_len    = (bus.cfg_len  == '0) ? (ADDR_WIDTH+1)'(1) : bus.cfg_len;
    assign w_cfg_pass   = (bus.cfg_pass == '0) ? PASS_WIDTH'(1)     : bus.cfg_pass;
    assign w_cfg_total  = CNT_WIDTH'(w_cfg_len) * CNT_WIDTH'(w_cfg_pass);

    // r_busy stays high through the done cycle, so a start there is also ignored
    assign w_start      = bus.start && (r_state == S_IDLE) && !r_busy;
    assign w_accept     = bus.in_valid &&
                          (w_start || ((r_state == S_RUN) && (r_acc_cnt < r_total)));

    assign w_rd_en      = r_vld[1];
    assign w_wr_en      = r_vld[2];
    assign w_last_addr  = ADDR_WIDTH'(r_len - (ADDR_WIDTH+1)'(1));
    assign w_final_pass = r_pass - PASS_WIDTH'(1);
    assign w_wr_final   = w_wr_en && (r_wr_pass == w_final_pass);
    assign w_wr_mem     = w_wr_en && (r_wr_pass <  w_final_pass);

    // A sum being written this cycle is the very operand being read (len == 1)
    assign w_bypass     = w_wr_en && (r_wr_addr == r_rd_addr) && (r_wr_pass != w_final_pass);

    always_comb begin
        w_fifo_data = '0;
        if (w_rd_en && (r_rd_pass != '0)) begin
            if (w_bypass) begin
                w_fifo_data = bus.sum_in;
            end else begin
                w_fifo_data = r_mem[r_rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_mem) begin
            r_mem[r_wr_addr] <= bus.sum_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_pass      <= '0;
            r_total     <= '0;
            r_acc_cnt   <= '0;
            r_vld       <= '0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_rd_pass   <= '0;
            r_wr_pass   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_vld       <= {r_vld[1:0], w_accept};

            if (w_rd_en) begin
                if (r_rd_addr == w_last_addr) begin
                    r_rd_addr <= '0;
                    r_rd_pass <= r_rd_pass + PASS_WIDTH'(1);
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                end
            end

            if (w_wr_en) begin
                if (r_wr_addr == w_last_addr) begin
                    r_wr_addr <= '0;
                    r_wr_pass <= r_wr_pass + PASS_WIDTH'(1);
                end else begin
                    r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                end
            end

            if (w_wr_final) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.sum_in;
            end

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_len     <= w_cfg_len;
                        r_pass    <= w_cfg_pass;
                        r_total   <= w_cfg_total;
                        r_acc_cnt <= CNT_WIDTH'(w_accept);
                        r_vld     <= {2'b00, w_accept};
                        r_rd_addr <= '0;
                        r_wr_addr <= '0;
                        r_rd_pass <= '0;
                        r_wr_pass <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= (w_accept && (w_cfg_total == CNT_WIDTH'(1))) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
                        if ((r_acc_cnt + CNT_WIDTH'(1)) == r_total) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_wr_final && (r_wr_addr == w_last_addr)) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_data = w_fifo_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_psum_fifo_ctrl.sv
// ============================================================================
//  Module   : tb_psum_fifo_ctrl
//  Purpose  : Randomized self-checking bench for psum_fifo_ctrl with a beat-level accumulation model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_fifo_ctrl;

    localparam int DW    = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int PW    = 8;
    localparam int MAXC  = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psum_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) bus ();

    psum_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .PASS_WIDTH(PW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle expectations for one job, cycle 0 being the start cycle
    logic          iv      [MAXC];
    logic          exp_ov  [MAXC];
    logic          exp_dn  [MAXC];
    logic [DW-1:0] exp_fd  [MAXC];
    logic [DW-1:0] exp_od  [MAXC];
    logic [DW-1:0] drv_sum [MAXC];

    task automatic run_job(input int len_cfg, input int pass_cfg, input int max_gap, input bit abuse);
        int len, pass, c, last, ncyc;
        logic [DW-1:0] acc [DEPTH];
        logic [DW-1:0] fd, s;
        len  = (len_cfg  == 0) ? 1 : len_cfg;
        pass = (pass_cfg == 0) ? 1 : pass_cfg;
        for (int i = 0; i < MAXC; i++) begin
            iv[i]      = 1'b0;
            exp_ov[i]  = 1'b0;
            exp_dn[i]  = 1'b0;
            exp_fd[i]  = '0;
            exp_od[i]  = '0;
            drv_sum[i] = DW'($urandom);
        end
        c    = 0;
        last = 0;
        for (int k = 0; k < len * pass; k++) begin
            fd = (k / len == 0) ? '0 : acc[k % len];
            s  = fd + DW'($urandom);
            acc[k % len] = s;
            iv[c]        = 1'b1;
            exp_fd[c+2]  = fd;
            drv_sum[c+3] = s;
            if (k / len == pass - 1) begin
                exp_ov[c+4] = 1'b1;
                exp_od[c+4] = s;
            end
            last = c;
            c    = c + 1 + int'($urandom_range(0, max_gap));
        end
        exp_dn[last+4] = 1'b1;
        if (abuse) begin
            for (int i = 1; i <= 6; i++) iv[last+i] = 1'b1;
        end
        ncyc = last + 9;
        for (int cy = 0; cy < ncyc; cy++) begin
            @(posedge clk);
            #1;
            bus.start    = (cy == 0) || (abuse && cy == 2);
            bus.cfg_len  = (cy == 0) ? (AW+1)'(len_cfg) : (AW+1)'($urandom_range(1, 64));
            bus.cfg_pass = (cy == 0) ? PW'(pass_cfg)    : PW'($urandom_range(1, 255));
            bus.in_valid = iv[cy];
            bus.sum_in   = drv_sum[cy];
            @(negedge clk);
            check($sformatf("fifo_data L%0d P%0d c%0d", len, pass, cy), 32'(bus.fifo_data), 32'(exp_fd[cy]));
            check($sformatf("out_valid L%0d P%0d c%0d", len, pass, cy), 32'(bus.out_valid), 32'(exp_ov[cy]));
            if (exp_ov[cy])
                check($sformatf("out_data L%0d P%0d c%0d", len, pass, cy), 32'(bus.out_data), 32'(exp_od[cy]));
            check($sformatf("done L%0d P%0d c%0d", len, pass, cy), 32'(bus.done), 32'(exp_dn[cy]));
            check($sformatf("busy L%0d P%0d c%0d", len, pass, cy), 32'(bus.busy),
                  32'((cy >= 1) && (cy <= last + 4)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fifo_data"}, 32'(bus.fifo_data), 32'd0);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data"},  32'(bus.out_data),  32'd0);
        check({tag, " busy"},      32'(bus.busy),      32'd0);
        check({tag, " done"},      32'(bus.done),      32'd0);
    endtask

    task automatic reset_mid_job();
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.cfg_len  = (AW+1)'(3);
        bus.cfg_pass = PW'(2);
        bus.in_valid = 1'b1;
        bus.sum_in   = DW'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            bus.sum_in = DW'($urandom);
        end
        // pass 1 is now being read back; abort asynchronously mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-job reset");
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("held reset");
        rst_n = 1'b1;
        run_job(3, 2, 1, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.cfg_len  = '0;
        bus.cfg_pass = '0;
        bus.in_valid = 1'b0;
        bus.sum_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        run_job(4, 1, 0, 1'b0);
        run_job(3, 2, 0, 1'b0);
        run_job(1, 3, 0, 1'b0);
        run_job(2, 2, 2, 1'b0);
        run_job(4, 3, 1, 1'b1);
        run_job(0, 0, 0, 1'b0);
        run_job(1, 1, 0, 1'b1);
        run_job(64, 2, 0, 1'b0);
        reset_mid_job();
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psum_fifo_ctrl.md
Name: psum_fifo_ctrl

Overview:
- Partial-sum buffer on the feedback side of the three-stage psum adder tree.
- Supplies the tree's fifo_data operand aligned to tree latency and captures the tree output. Injects zero on the first input-channel pass.
- Stores intermediate sums between passes and streams the final sums of the last pass out to the output/requant stage.

Parameters:
- data_width, 25, width of partial sums (matches adder tree).
- depth, 64, max psums per pass (output pixels per tile).
- addr_width, 6, log2(depth).
- pass_width, 8, width of pass-count field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_len/cfg_pass and begins a job.
- cfg_len  in  addr_width+1  psums per pass, legal 1..depth.
- cfg_pass  in  pass_width  number of passes, legal 1..2^pass_width-1.
- in_valid  in  1  PE data presented to the adder tree this cycle.
- sum_in  in  data_width  adder tree output.
- fifo_data  out  data_width  operand to adder tree (combinational from buffer/bypass).
- out_valid  out  1  final sum valid.
- out_data  out  data_width  final sum.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse, job complete.

Behaviour:
- Reset: all outputs 0; counters 0; state IDLE. Buffer contents need not be cleared. Reset mid-job aborts immediately, with no done pulse.
- Tree timing is fixed. in_valid at cycle t means fifo_data must be correct during cycle t+2, and sum_in is the completed sum during cycle t+3.
- A 3-deep valid shift register tracks this timing:
  - rd_en is in_valid delayed 2.
  - wr_en is in_valid delayed 3.
- Read side:
  - rd_addr increments on each rd_en and wraps len-1 -> 0.
  - rd_pass increments on each wrap.
  - fifo_data = 0 when rd_pass == 0 or when rd_en is low.
  - Otherwise fifo_data = mem[rd_addr].
  - Bypass: if wr_en is high, wr_addr == rd_addr and wr_pass != final pass, fifo_data = sum_in. This makes len == 1 legal.
- Write side:
  - wr_addr and wr_pass follow the same wrap rules as the read side.
  - When wr_pass < cfg_pass-1: mem[wr_addr] <= sum_in, and out_valid stays low.
  - On the final pass there is no memory write. out_valid <= 1 and out_data <= sum_in, registered, so they appear at cycle t+4.
- Signed two's-complement data is passed unmodified; there is no saturation (the tree wraps).
- FSM states:
  - IDLE: busy = 0. start -> RUN; latch cfg, clear all counters and the valid shift register.
  - RUN: busy = 1. Counts accepted in_valid. After len*cfg_pass accepted -> DRAIN.
    - in_valid beyond that count is ignored and not entered into the shift register.
  - DRAIN: busy = 1. Waits until the final wr_en is processed. The next cycle asserts done together with the last out_valid -> IDLE.
- Boundary and ignore rules:
  - start while busy is ignored.
  - in_valid while IDLE is ignored (fifo_data = 0).
  - start and in_valid in the same cycle: that in_valid counts as element 0.
  - cfg_pass == 1: every sum goes to output, with no memory write and fifo_data always 0.
  - cfg_len == 0 or cfg_pass == 0: illegal; treated as 1.
- in_valid may have gaps; the pipeline tracks each beat independently, so bubbles need no special handling.
- busy deasserts the cycle after done.

Test Plan:
- Single pass: len=4, pass=1, in_valid 4 consecutive cycles, sum_in = 10, 20, 30, 40 at t+3 -> fifo_data always 0; out_data 10, 20, 30, 40 at t+4..t+7; done with the last; no memory writes.
- Two passes, len=3: pass-0 sums 5, 6, 7 written; pass-1 fifo_data reads 5, 6, 7 at t+2; tree sum_in 15, 16, 17 emitted on out_data; done after the 6th beat.
- Bypass, len=1, pass=3, continuous in_valid: fifo_data at beat 1 equals the same-cycle sum_in of beat 0 (e.g. 100); final out equals the full 3-pass accumulation.
- Bubbles and signed data: len=2, pass=2, in_valid 1,0,1,0,0,1,1 with negative sums (-8, 3) -> fifo_data -8 then 3 aligned to each beat's t+2; correct outputs; no mis-indexing.
- Protocol abuse: start while busy ignored; extra in_valid after the last beat ignored; in_valid in IDLE leaves fifo_data=0 and out_valid=0.
- Reset mid-job: assert rst_n=0 during pass 1 -> all outputs 0 at once; no done; a new start after release runs a clean job with pass 0 reading zeros.
